game_round_ctrl: RTL and testbench

Round sequencer for the BCD math game. Configures and enables the two-digit countdown timer, requests a new problem each round, judges the player's answer against the timer timeout, and keeps BCD score, lives and difficulty. It sits between the answer-check logic and the timer and owns `timer_en`, `timer_reconfig` and `difficulty`.

---
 rtl/game_round_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
//
// Round sequencer for the BCD math game. Each round loads and starts the
// two-digit countdown timer and asks for a new problem. It then waits for
// exactly one judged event: a timer expiry or an answer. It keeps the BCD
// score, the remaining lives and the difficulty, and it owns the timer
// controls.
//
// Round flow:
//   IDLE -> LOAD -> RUN -> JUDGE -> PAUSE -> LOAD ... and JUDGE -> OVER
//   when the last life is lost. Leave OVER with start.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high, clears all state
//   start          in   level, starts a game from IDLE or OVER
//   answer_valid   in   one-cycle strobe, the player submitted an answer
//   answer_correct in   qualifies answer_valid, 1 = correct
//   time_out       in   timer expired (level)
//   timer_en       out  enables the timer countdown tick (high in RUN)
//   timer_reconfig out  one-cycle pulse, reloads the timer from difficulty
//   difficulty     out  [3:0] difficulty sent to the timer
//   new_problem    out  one-cycle pulse requesting the next problem
//   score_tens     out  [3:0] BCD tens digit of the score
//   score_ones     out  [3:0] BCD ones digit of the score
//   lives          out  [2:0] remaining lives
//   game_over      out  high while in OVER
// -----------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned STREAK_UP    = 3,
  parameter int unsigned MIN_DIFF     = 1,
  parameter int unsigned MAX_DIFF     = 9,
  parameter int unsigned PAUSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       answer_valid,
  input  logic       answer_correct,
  input  logic       time_out,
  output logic       timer_en,
  output logic       timer_reconfig,
  output logic [3:0] difficulty,
  output logic       new_problem,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int SW = $clog2(STREAK_UP + 1);
  localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_JUDGE,
    S_PAUSE,
    S_OVER
  } state_t;

  state_t        r_state;
  logic          r_timer_en;
  logic          r_timer_reconfig;
  logic          r_new_problem;
  logic [3:0]    r_difficulty;
  logic [3:0]    r_score_tens;
  logic [3:0]    r_score_ones;
  logic [2:0]    r_lives;
  logic          r_game_over;
  logic [SW-1:0] r_streak;
  logic [PW-1:0] r_pause;

  logic [SW-1:0] w_streak_nxt;
  logic [7:0]    w_score_inc;

  // Increment a two-digit BCD score and saturate at 99.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                         input logic [3:0] ones);
    logic [7:0] res;
    if (tens == 4'd9 && ones == 4'd9) res = {tens, ones};
    else if (ones == 4'd9)            res = {tens + 4'd1, 4'd0};
    else                              res = {tens, ones + 4'd1};
    return res;
  endfunction

  // Decrement the lives count. Stop at zero so it never wraps.
  function automatic logic [2:0] lives_dec(input logic [2:0] l);
    return (l == 3'd0) ? 3'd0 : l - 3'd1;
  endfunction

  // Increment the difficulty. Saturate at MAX_DIFF.
  function automatic logic [3:0] diff_inc(input logic [3:0] d);
    return (d >= 4'(MAX_DIFF)) ? 4'(MAX_DIFF) : d + 4'd1;
  endfunction

  assign w_streak_nxt = r_streak + SW'(1);
  assign w_score_inc  = bcd_inc(r_score_tens, r_score_ones);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_timer_en       <= 1'b0;
      r_timer_reconfig <= 1'b0;
      r_new_problem    <= 1'b0;
      r_difficulty     <= 4'(MIN_DIFF);
      r_score_tens     <= 4'd0;
      r_score_ones     <= 4'd0;
      r_lives          <= 3'(LIVES);
      r_game_over      <= 1'b0;
      r_streak         <= '0;
      r_pause          <= '0;
    end else begin
      // The pulse outputs are high only on the cycle after a LOAD entry.
      r_timer_reconfig <= 1'b0;
      r_new_problem    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer_en <= 1'b0;
          if (start) begin
            r_state          <= S_LOAD;
            r_timer_reconfig <= 1'b1;
            r_new_problem    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_timer_en <= 1'b1;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          // time_out wins, and an answer in the same cycle is dropped.
          if (time_out) begin
            r_lives    <= lives_dec(r_lives);
            r_streak   <= '0;
            r_timer_en <= 1'b0;
            r_state    <= S_JUDGE;
          end else if (answer_valid) begin
            if (answer_correct) begin
              r_score_tens <= w_score_inc[7:4];
              r_score_ones <= w_score_inc[3:0];
              if (w_streak_nxt == SW'(STREAK_UP)) begin
                r_streak     <= '0;
                r_difficulty <= diff_inc(r_difficulty);
              end else begin
                r_streak <= w_streak_nxt;
              end
            end else begin
              r_lives  <= lives_dec(r_lives);
              r_streak <= '0;
            end
            r_timer_en <= 1'b0;
            r_state    <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          r_timer_en <= 1'b0;
          if (r_lives == 3'd0) begin
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_pause <= PW'(PAUSE_CYCLES - 1);
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          r_timer_en <= 1'b0;
          if (r_pause == '0) begin
            r_state          <= S_LOAD;
            r_timer_reconfig <= 1'b1;
            r_new_problem    <= 1'b1;
          end else begin
            r_pause <= r_pause - PW'(1);
          end
        end
        S_OVER: begin
          r_timer_en <= 1'b0;
          // The score stays visible until the next game starts.
          if (start) begin
            r_lives          <= 3'(LIVES);
            r_score_tens     <= 4'd0;
            r_score_ones     <= 4'd0;
            r_streak         <= '0;
            r_difficulty     <= 4'(MIN_DIFF);
            r_game_over      <= 1'b0;
            r_state          <= S_LOAD;
            r_timer_reconfig <= 1'b1;
            r_new_problem    <= 1'b1;
          end
        end
        default: begin
          r_timer_en <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign timer_en       = r_timer_en;
  assign timer_reconfig = r_timer_reconfig;
  assign difficulty     = r_difficulty;
  assign new_problem    = r_new_problem;
  assign score_tens     = r_score_tens;
  assign score_ones     = r_score_ones;
  assign lives          = r_lives;
  assign game_over      = r_game_over;

endmodule

// File: tb/tb_game_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_round_ctrl
//
// Directed bench for game_round_ctrl with default parameters:
// LIVES=3, STREAK_UP=3, MIN_DIFF=1, MAX_DIFF=9, PAUSE_CYCLES=4.
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, so each check sees the state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_game_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       answer_valid;
  logic       answer_correct;
  logic       time_out;
  logic       timer_en;
  logic       timer_reconfig;
  logic [3:0] difficulty;
  logic       new_problem;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [2:0] lives;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  game_round_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .answer_valid   (answer_valid),
    .answer_correct (answer_correct),
    .time_out       (time_out),
    .timer_en       (timer_en),
    .timer_reconfig (timer_reconfig),
    .difficulty     (difficulty),
    .new_problem    (new_problem),
    .score_tens     (score_tens),
    .score_ones     (score_ones),
    .lives          (lives),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Play one round. The call starts on the first RUN cycle.
  // kind: 0 = correct, 1 = wrong, 2 = time_out, 3 = time_out with a correct answer.
  // exp_score is the expected score as a plain integer (0..99).
  // over = 1 means the round is expected to end the game.
  task automatic play(input int kind, input int exp_score, input int exp_lives,
                      input int exp_diff, input bit over);
    logic [7:0] es;
    es = {4'(exp_score / 10), 4'(exp_score % 10)};
    chk("run_en", {7'd0, timer_en}, 8'd1);
    case (kind)
      0: begin answer_valid = 1'b1; answer_correct = 1'b1; end
      1: begin answer_valid = 1'b1; answer_correct = 1'b0; end
      2: begin time_out = 1'b1; end
      default: begin time_out = 1'b1; answer_valid = 1'b1; answer_correct = 1'b1; end
    endcase
    step();
    answer_valid = 1'b0; answer_correct = 1'b0; time_out = 1'b0;
    // JUDGE
    chk("judge_en", {7'd0, timer_en}, 8'd0);
    chk("score", {score_tens, score_ones}, es);
    chk("lives", {5'd0, lives}, 8'(exp_lives));
    chk("diff", {4'd0, difficulty}, 8'(exp_diff));
    step();
    if (over) begin
      chk("over_flag", {7'd0, game_over}, 8'd1);
      chk("over_en", {7'd0, timer_en}, 8'd0);
    end else begin
      // PAUSE: four cycles. Answers and start must be ignored here.
      answer_valid = 1'b1; answer_correct = 1'b1; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk("pause_np", {7'd0, new_problem}, 8'd0);
        chk("pause_en", {7'd0, timer_en}, 8'd0);
        if (i == 3) begin answer_valid = 1'b0; answer_correct = 1'b0; start = 1'b0; end
        step();
      end
      // LOAD
      chk("load_np", {7'd0, new_problem}, 8'd1);
      chk("load_rc", {7'd0, timer_reconfig}, 8'd1);
      chk("pause_score", {score_tens, score_ones}, es);
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; answer_valid = 1'b0;
    answer_correct = 1'b0; time_out = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1: reset values and the start-to-RUN latency.
    chk("rst_en", {7'd0, timer_en}, 8'd0);
    chk("rst_rc", {7'd0, timer_reconfig}, 8'd0);
    chk("rst_np", {7'd0, new_problem}, 8'd0);
    chk("rst_diff", {4'd0, difficulty}, 8'd1);
    chk("rst_score", {score_tens, score_ones}, 8'h00);
    chk("rst_lives", {5'd0, lives}, 8'd3);
    chk("rst_go", {7'd0, game_over}, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_rc1", {7'd0, timer_reconfig}, 8'd1);
    chk("load_np1", {7'd0, new_problem}, 8'd1);
    chk("load_en1", {7'd0, timer_en}, 8'd0);
    step();
    chk("run_rc1", {7'd0, timer_reconfig}, 8'd0);
    chk("run_np1", {7'd0, new_problem}, 8'd0);
    chk("run_en1", {7'd0, timer_en}, 8'd1);
    step();  // an idle RUN cycle changes nothing
    chk("run_idle_lives", {5'd0, lives}, 8'd3);
    chk("run_idle_en", {7'd0, timer_en}, 8'd1);

    // 2: three correct answers. Difficulty rises after the third.
    play(0, 1, 3, 1, 0);
    play(0, 2, 3, 1, 0);
    play(0, 3, 3, 2, 0);

    // 3: time_out beats a simultaneous correct answer and clears the streak.
    play(0, 4, 3, 2, 0);      // streak 1
    play(3, 4, 2, 2, 0);      // streak 0
    play(0, 5, 2, 2, 0);
    play(0, 6, 2, 2, 0);      // streak 2, so difficulty has not risen

    // 4: lose the remaining lives, then check OVER behaviour and the restart.
    play(1, 6, 1, 2, 0);
    play(2, 6, 0, 2, 1);
    answer_valid = 1'b1; answer_correct = 1'b1;
    step();
    answer_valid = 1'b0; answer_correct = 1'b0;
    step();
    chk("over_hold_score", {score_tens, score_ones}, 8'h06);
    chk("over_hold_go", {7'd0, game_over}, 8'd1);
    chk("over_hold_lives", {5'd0, lives}, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_rc", {7'd0, timer_reconfig}, 8'd1);
    chk("restart_lives", {5'd0, lives}, 8'd3);
    chk("restart_score", {score_tens, score_ones}, 8'h00);
    chk("restart_diff", {4'd0, difficulty}, 8'd1);
    chk("restart_go", {7'd0, game_over}, 8'd0);
    step();

    // 5: BCD carry 09 -> 10, saturation at 99, difficulty saturation at 9.
    for (int i = 1; i <= 102; i++) begin
      int es;
      int ed;
      es = (i > 99) ? 99 : i;
      ed = (1 + i / 3 > 9) ? 9 : 1 + i / 3;
      play(0, es, 3, ed, 0);
    end

    // 6: reset during RUN, then an answer in IDLE is ignored.
    chk("pre_rst_en", {7'd0, timer_en}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_en", {7'd0, timer_en}, 8'd0);
    chk("mid_rst_score", {score_tens, score_ones}, 8'h00);
    chk("mid_rst_lives", {5'd0, lives}, 8'd3);
    chk("mid_rst_diff", {4'd0, difficulty}, 8'd1);
    answer_valid = 1'b1; answer_correct = 1'b1;
    step();
    answer_valid = 1'b0; answer_correct = 1'b0;
    step();
    chk("idle_ans_score", {score_tens, score_ones}, 8'h00);
    chk("idle_ans_en", {7'd0, timer_en}, 8'd0);
    chk("idle_ans_np", {7'd0, new_problem}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
